// File: rtl/toy_sa_skew_ctrl.sv
// Feed/drain controller for a ROWS x DW systolic array: broadcasts weights in LOAD,
// applies a diagonal input skew in COMPUTE and re-aligns the skewed array results.
module toy_sa_skew_ctrl #(
    parameter int ROWS  = 8,
    parameter int DW    = 32,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [ROWS*DW-1:0] vec_data,
    output logic [ROWS*DW-1:0] sa_din,
    output logic [ROWS-1:0]    sa_load_en,
    output logic [ROWS-1:0]    sa_shift_en,
    input  logic [ROWS*DW-1:0] sa_dout,
    input  logic [ROWS-1:0]    sa_dout_en,
    output logic               res_valid,
    output logic [ROWS*DW-1:0] res_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // state   | meaning
    // S_IDLE  | waiting for a command
    // S_LOAD  | broadcasting weight vectors with sa_load_en
    // S_FEED  | accepting input vectors into the diagonal skew
    // S_FLUSH | skew draining, waiting for all results to return
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d, n_iss_q, n_iss_d, n_res_q, n_res_d, iss_inc;
    logic               cmd_ready_q, cmd_ready_d, vec_ready_q, vec_ready_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic [ROWS*DW-1:0] res_data_q, res_data_d, sa_din_q, sa_din_d;
    logic [ROWS-1:0]    sa_load_en_q, sa_load_en_d, sa_shift_en_q, sa_shift_en_d;

    logic               cmd_acc, vec_acc, load_acc, feed_acc;
    logic               in_cmp, fire, partial, skew_empty;
    logic [ROWS-1:0]    src_v, pipe_busy, al_en;
    logic [ROWS*DW-1:0] src_d, al_dat;

    assign cmd_acc  = cmd_valid & cmd_ready_q;
    assign vec_acc  = vec_valid & vec_ready_q;
    assign load_acc = vec_acc & (state_q == S_LOAD);
    assign feed_acc = vec_acc & (state_q == S_FEED);
    assign iss_inc  = n_iss_q + LEN_W'(1);

    assign src_v[0]        = feed_acc;
    assign src_d[DW-1:0]   = vec_data[DW-1:0];
    assign pipe_busy[0]    = 1'b0;

    // Row r gets r extra delay stages ahead of its output register.
    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [r-1:0]    sv_q, sv_d;
        logic [r*DW-1:0] sd_q, sd_d;
        always_comb begin
            sv_d = sv_q;
            sd_d = sd_q;
            sv_d[0]      = feed_acc;
            sd_d[DW-1:0] = vec_data[r*DW +: DW];
            for (int k = 1; k < r; k++) begin
                sv_d[k]         = sv_q[k-1];
                sd_d[k*DW +: DW] = sd_q[(k-1)*DW +: DW];
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sv_q <= '0;
                sd_q <= '0;
            end else begin
                sv_q <= sv_d;
                sd_q <= sd_d;
            end
        end
        assign src_v[r]          = sv_q[r-1];
        assign src_d[r*DW +: DW] = sd_q[(r-1)*DW +: DW];
        assign pipe_busy[r]      = |sv_q;
    end

    // Row r result is delayed ROWS-1-r cycles so all rows of one vector line up.
    for (genvar r = 0; r < ROWS; r++) begin : g_deskew
        localparam int D = ROWS - 1 - r;
        if (D == 0) begin : g_direct
            assign al_en[r]           = sa_dout_en[r];
            assign al_dat[r*DW +: DW] = sa_dout[r*DW +: DW];
        end else begin : g_delay
            logic [D-1:0]    en_q, en_d;
            logic [D*DW-1:0] dat_q, dat_d;
            always_comb begin
                en_d = en_q;
                dat_d = dat_q;
                en_d[0]       = sa_dout_en[r];
                dat_d[DW-1:0] = sa_dout[r*DW +: DW];
                for (int k = 1; k < D; k++) begin
                    en_d[k]           = en_q[k-1];
                    dat_d[k*DW +: DW] = dat_q[(k-1)*DW +: DW];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_q  <= '0;
                    dat_q <= '0;
                end else begin
                    en_q  <= en_d;
                    dat_q <= dat_d;
                end
            end
            assign al_en[r]           = en_q[D-1];
            assign al_dat[r*DW +: DW] = dat_q[(D-1)*DW +: DW];
        end
    end

    assign in_cmp     = (state_q == S_FEED) || (state_q == S_FLUSH);
    assign fire       = in_cmp & (&al_en);
    assign partial    = (|al_en) & ~(&al_en);
    assign skew_empty = ~(|pipe_busy) & ~(|sa_shift_en_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        n_iss_d = n_iss_q;
        n_res_d = fire ? n_res_q + LEN_W'(1) : n_res_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_acc) begin
                len_d   = cmd_len;
                n_iss_d = '0;
                n_res_d = '0;
                if (cmd_len == '0) done_d = 1'b1;
                else state_d = cmd_mode ? S_FEED : S_LOAD;
            end
            S_LOAD: begin
                if (load_acc) n_iss_d = iss_inc;
                if (n_iss_q == len_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FEED: if (feed_acc) begin
                n_iss_d = iss_inc;
                if (iss_inc == len_q) state_d = S_FLUSH;
            end
            S_FLUSH: if (skew_empty && (n_res_q == len_q)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        vec_ready_d = ((state_d == S_LOAD) || (state_d == S_FEED)) && (n_iss_d < len_d);

        sa_load_en_d  = {ROWS{load_acc}};
        sa_shift_en_d = src_v;
        sa_din_d      = load_acc ? vec_data : sa_din_q;
        for (int r = 0; r < ROWS; r++) begin
            if (src_v[r]) sa_din_d[r*DW +: DW] = src_d[r*DW +: DW];
        end

        res_valid_d = fire;
        res_data_d  = fire ? al_dat : res_data_q;
        err_d       = err_q | partial | (~in_cmp & (|sa_dout_en));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            n_iss_q       <= '0;
            n_res_q       <= '0;
            cmd_ready_q   <= 1'b0;
            vec_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            sa_din_q      <= '0;
            sa_load_en_q  <= '0;
            sa_shift_en_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            n_iss_q       <= n_iss_d;
            n_res_q       <= n_res_d;
            cmd_ready_q   <= cmd_ready_d;
            vec_ready_q   <= vec_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            sa_din_q      <= sa_din_d;
            sa_load_en_q  <= sa_load_en_d;
            sa_shift_en_q <= sa_shift_en_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign vec_ready   = vec_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign sa_din      = sa_din_q;
    assign sa_load_en  = sa_load_en_q;
    assign sa_shift_en = sa_shift_en_q;

endmodule

// File: tb/tb_toy_sa_skew_ctrl.sv
// Directed bench for toy_sa_skew_ctrl with ROWS=4, DW=8: per-cycle vector table
// followed by hand-written skew/de-skew, error, zero-length and reset sequences.
module tb_toy_sa_skew_ctrl;
    localparam int ROWS = 4;
    localparam int DW = 8;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid, cmd_ready, cmd_mode, vec_valid, vec_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [ROWS*DW-1:0] vec_data, sa_din, sa_dout, res_data;
    logic [ROWS-1:0] sa_load_en, sa_shift_en, sa_dout_en;
    logic res_valid, busy, done, err;
    logic [77:0] obs;

    always #5 clk = ~clk;

    toy_sa_skew_ctrl #(.ROWS(ROWS), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .sa_din(sa_din), .sa_load_en(sa_load_en), .sa_shift_en(sa_shift_en),
        .sa_dout(sa_dout), .sa_dout_en(sa_dout_en),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    assign obs = {cmd_ready, vec_ready, sa_load_en, sa_shift_en, sa_din,
                  busy, done, err, res_valid, res_data};

    typedef struct {
        logic        cv, cm, vv;
        logic [7:0]  cl;
        logic [31:0] vd, dout;
        logic [3:0]  den;
        logic [77:0] exp;
    } row_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chkb(input string nm, input logic [77:0] act, input logic [77:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic row_t mk(input logic [31:0] cv, cm, cl, vv, vd, den, dout,
                                input logic [31:0] cr, vr, ld, sh, din, bz, dn, er, rv, rd);
        row_t t;
        t.cv = cv[0]; t.cm = cm[0]; t.cl = cl[7:0]; t.vv = vv[0];
        t.vd = vd; t.den = den[3:0]; t.dout = dout;
        t.exp = {cr[0], vr[0], ld[3:0], sh[3:0], din, bz[0], dn[0], er[0], rv[0], rd};
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        row_t tbl[20];
        logic [31:0] vv_tab[3];
        logic [31:0] exp_din, exp_rd;
        logic [3:0]  exp_sh;
        logic        exp_rv, exp_done, gap;
        int          acc[3];
        int          nacc, nres_seen, wait_cnt;

        cmd_valid = 0; cmd_mode = 0; cmd_len = '0;
        vec_valid = 0; vec_data = '0; sa_dout = '0; sa_dout_en = '0;

        // LOAD len=2
        tbl[0]  = mk(1,0,2,0,0,0,0,                 1,0,0,0,32'h00000000,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,1,32'h04030201,0,0,      0,1,0,0,32'h00000000,1,0,0,0,0);
        tbl[2]  = mk(0,0,0,1,32'h08070605,0,0,      0,1,4'hF,0,32'h04030201,1,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,                 0,0,4'hF,0,32'h08070605,1,0,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,0,                 1,0,0,0,32'h08070605,0,1,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,                 1,0,0,0,32'h08070605,0,0,0,0,0);
        // COMPUTE len=1 plus a skewed result from a model array
        tbl[6]  = mk(1,1,1,0,0,0,0,                 1,0,0,0,32'h08070605,0,0,0,0,0);
        tbl[7]  = mk(0,0,0,1,32'h0D0C0B0A,0,0,      0,1,0,0,32'h08070605,1,0,0,0,0);
        tbl[8]  = mk(0,0,0,0,0,0,0,                 0,0,0,1,32'h0807060A,1,0,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,                 0,0,0,2,32'h08070B0A,1,0,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,0,                 0,0,0,4,32'h080C0B0A,1,0,0,0,0);
        tbl[11] = mk(0,0,0,0,0,0,0,                 0,0,0,8,32'h0D0C0B0A,1,0,0,0,0);
        tbl[12] = mk(0,0,0,0,0,0,0,                 0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[13] = mk(0,0,0,0,0,0,0,                 0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[14] = mk(0,0,0,0,0,1,32'h00000011,      0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[15] = mk(0,0,0,0,0,2,32'h00002200,      0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[16] = mk(0,0,0,0,0,4,32'h00330000,      0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[17] = mk(0,0,0,0,0,8,32'h44000000,      0,0,0,0,32'h0D0C0B0A,1,0,0,0,0);
        tbl[18] = mk(0,0,0,0,0,0,0,                 0,0,0,0,32'h0D0C0B0A,1,0,0,1,32'h44332211);
        tbl[19] = mk(0,0,0,0,0,0,0,                 1,0,0,0,32'h0D0C0B0A,0,1,0,0,32'h44332211);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("reset_outputs", obs, '0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            cmd_valid = tbl[i].cv; cmd_mode = tbl[i].cm; cmd_len = tbl[i].cl;
            vec_valid = tbl[i].vv; vec_data = tbl[i].vd;
            sa_dout_en = tbl[i].den; sa_dout = tbl[i].dout;
            @(negedge clk);
            chkb($sformatf("table_row%0d", i), obs, tbl[i].exp);
            @(posedge clk); #1;
        end

        // COMPUTE len=3 with one gap after vector 1; model array returns row r at accept+6+r
        vv_tab[0] = 32'h13121110; vv_tab[1] = 32'h23222120; vv_tab[2] = 32'h33323130;
        exp_din = 32'h0D0C0B0A;
        cmd_valid = 1; cmd_mode = 1; cmd_len = 8'd3;
        wait_cnt = 0;
        @(negedge clk);
        while (!cmd_ready && wait_cnt < 20) begin
            @(posedge clk); @(negedge clk);
            wait_cnt++;
        end
        chk("len3_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 0;
        nacc = 0; nres_seen = 0; gap = 0;
        for (int k = 0; k < 20; k++) begin
            if (nacc == 2 && !gap) begin
                vec_valid = 0;
                gap = 1;
            end else begin
                vec_valid = (nacc < 3);
            end
            vec_data = vv_tab[(nacc < 3) ? nacc : 0];
            sa_dout_en = '0; sa_dout = '0;
            for (int i = 0; i < nacc; i++)
                for (int r = 0; r < ROWS; r++)
                    if (k == acc[i] + 6 + r) begin
                        sa_dout_en[r] = 1'b1;
                        sa_dout[r*DW +: DW] = vv_tab[i][r*DW +: DW] ^ 8'hA5;
                    end
            @(negedge clk);
            exp_sh = '0;
            for (int i = 0; i < nacc; i++)
                for (int r = 0; r < ROWS; r++)
                    if (k == acc[i] + 1 + r) begin
                        exp_sh[r] = 1'b1;
                        exp_din[r*DW +: DW] = vv_tab[i][r*DW +: DW];
                    end
            chkb($sformatf("skew_k%0d", k), 78'({sa_shift_en, sa_din}), 78'({exp_sh, exp_din}));
            exp_rv = 0; exp_rd = '0;
            for (int i = 0; i < nacc; i++)
                if (k == acc[i] + 10) begin
                    exp_rv = 1;
                    exp_rd = vv_tab[i] ^ 32'hA5A5A5A5;
                end
            chk($sformatf("res_valid_k%0d", k), 32'(res_valid), 32'(exp_rv));
            if (exp_rv) chk($sformatf("res_data_k%0d", k), res_data, exp_rd);
            if (res_valid) nres_seen++;
            exp_done = (nacc == 3) && (k == acc[2] + 11);
            chk($sformatf("done_k%0d", k), 32'(done), 32'(exp_done));
            if (vec_valid && vec_ready && nacc < 3) begin
                acc[nacc] = k;
                nacc++;
            end
            @(posedge clk); #1;
        end
        vec_valid = 0; sa_dout_en = '0; sa_dout = '0;
        chk("len3_accepts", nacc, 3);
        chk("len3_result_pulses", nres_seen, 3);
        @(negedge clk);
        chk("len3_err", 32'(err), 32'd0);
        chk("len3_busy_end", 32'(busy), 32'd0);

        // lone row-2 result while idle
        @(posedge clk); #1 sa_dout_en = 4'b0100; sa_dout = 32'h00FF0000;
        @(posedge clk); #1 sa_dout_en = '0; sa_dout = '0;
        @(negedge clk);
        chk("inject_err_set", 32'(err), 32'd1);
        chk("inject_no_res", 32'(res_valid), 32'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("inject_no_res_later", 32'(res_valid), 32'd0);
        end
        chk("inject_err_sticky", 32'(err), 32'd1);

        // zero-length command
        @(posedge clk); #1 cmd_valid = 1; cmd_mode = 0; cmd_len = '0;
        @(negedge clk);
        chk("len0_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 0;
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("len0_done_clear", 32'(done), 32'd0);
        chk("len0_busy_after", 32'(busy), 32'd0);

        // reset in the middle of FEED
        @(posedge clk); #1 cmd_valid = 1; cmd_mode = 1; cmd_len = 8'd5;
        @(posedge clk); #1 cmd_valid = 0; vec_valid = 1; vec_data = 32'h44434241;
        @(posedge clk); #1 vec_data = 32'h54535251;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midfeed_busy", 32'(busy), 32'd1);
        chk("midfeed_shift", 32'(sa_shift_en), 32'h3);
        #2 rst_n = 0;
        #1 chkb("midfeed_reset_outputs", obs, '0);
        vec_valid = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_err", 32'(err), 32'd0);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("post_reset_no_done", 32'(done), 32'd0);
        end
        chk("post_reset_vec_ready", 32'(vec_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
